// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage: PC, imem handshake, IF/ID register,
//               one-entry hold buffer, branch redirect and halt detection.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_next,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    localparam logic [ADDR_W-1:0] c_step       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] c_align_mask = ~(ADDR_W'(PC_STEP - 1));

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic [ADDR_W-1:0]    w_pc_inc;
    logic                 r_if_valid;
    logic                 w_if_valid_nxt;
    logic [INSTR_W-1:0]   r_if_instr;
    logic [INSTR_W-1:0]   w_if_instr_nxt;
    logic [ADDR_W-1:0]    r_if_pc;
    logic [ADDR_W-1:0]    w_if_pc_nxt;
    logic [INSTR_W-1:0]   r_hold_instr;
    logic [INSTR_W-1:0]   w_hold_instr_nxt;
    logic                 w_accept;
    logic                 w_load;
    logic [INSTR_W-1:0]   w_load_instr;

    assign w_pc_inc   = r_pc + c_step;
    assign w_accept   = !stall || !r_if_valid;

    assign imem_req   = (r_state == FETCH) && !rst;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign if_valid   = r_if_valid;
    assign if_instr   = r_if_instr;
    assign if_pc      = r_if_pc;
    assign if_pc_next = r_if_pc + c_step;
    assign halted     = (r_state == HALT);

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_if_valid_nxt   = r_if_valid;
        w_if_instr_nxt   = r_if_instr;
        w_if_pc_nxt      = r_if_pc;
        w_hold_instr_nxt = r_hold_instr;
        w_load           = 1'b0;
        w_load_instr     = imem_data;

        // Without stall the current IF/ID entry is consumed this edge.
        if (!stall) begin
            w_if_valid_nxt = 1'b0;
        end

        if (branch_taken) begin
            w_pc_nxt         = branch_target & c_align_mask;
            w_if_valid_nxt   = 1'b0;
            w_hold_instr_nxt = '0;
            w_state_nxt      = FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        if (w_accept) begin
                            w_load       = 1'b1;
                            w_load_instr = imem_data;
                        end else begin
                            w_hold_instr_nxt = imem_data;
                            w_state_nxt      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        w_load       = 1'b1;
                        w_load_instr = r_hold_instr;
                    end
                end
                HALT: begin
                    w_state_nxt = HALT;
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase

            // The PC stays on a halt word so a later redirect decides where to go.
            if (w_load) begin
                w_if_valid_nxt = 1'b1;
                w_if_instr_nxt = w_load_instr;
                w_if_pc_nxt    = r_pc;
                if (w_load_instr[INSTR_W-1 -: 4] == HALT_OP) begin
                    w_state_nxt = HALT;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_instr   <= '0;
            r_if_pc      <= '0;
            r_hold_instr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
        end
    end

endmodule

`default_nettype wire
